// File: rtl/audio_sample_reader.sv
// Streams 16-bit audio samples out of 32-bit flash words, one sample per
// rising edge of the divided sample clock, playing forward or backward.
module audio_sample_reader #(
    parameter logic [22:0] ADDR_MAX = 23'h7FFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sample_clk,
    input  logic        play,
    input  logic        direction,
    input  logic        restart,
    input  logic        flash_waitrequest,
    input  logic [31:0] flash_readdata,
    input  logic        flash_readdatavalid,
    output logic        flash_read,
    output logic [22:0] flash_address,
    output logic [3:0]  flash_byteenable,
    output logic [15:0] audio_data,
    output logic        audio_valid,
    output logic        underrun
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT_DATA,
        S_WAIT_EDGE1,
        S_WAIT_EDGE2
    } state_t;

    state_t      state_q, state_d;
    logic [22:0] addr_q, addr_d;
    logic        read_q, read_d;
    logic [15:0] data_q, data_d;
    logic        valid_q, valid_d;
    logic        underrun_q, underrun_d;
    logic [31:0] word_q, word_d;
    logic        edge_pending_q, edge_pending_d;
    logic        restart_pending_q, restart_pending_d;
    logic        sync1_q, sync2_q, prev_q;

    logic        sample_edge;
    logic [22:0] start_addr;
    logic [22:0] step_addr;
    state_t      run_state;

    assign sample_edge = sync2_q & ~prev_q;
    assign start_addr  = direction ? ADDR_MAX : 23'd0;
    assign step_addr   = direction ? ((addr_q == 23'd0) ? ADDR_MAX : addr_q - 23'd1)
                                   : ((addr_q == ADDR_MAX) ? 23'd0 : addr_q + 23'd1);
    assign run_state   = play ? S_FETCH : S_IDLE;

    // Next-state and output computation for the fetch/playback sequencer.
    always_comb begin
        state_d           = state_q;
        addr_d            = addr_q;
        data_d            = data_q;
        valid_d           = 1'b0;
        underrun_d        = underrun_q;
        word_d            = word_q;
        edge_pending_d    = edge_pending_q;
        restart_pending_d = restart_pending_q;

        case (state_q)
            S_IDLE: begin
                if (restart) begin
                    addr_d         = start_addr;
                    edge_pending_d = 1'b0;
                    state_d        = run_state;
                end else if (play) begin
                    state_d = S_FETCH;
                end
            end

            S_FETCH, S_WAIT_DATA: begin
                // The bus transaction cannot be aborted, so restart is deferred.
                if (restart) begin
                    restart_pending_d = 1'b1;
                end
                // Only one edge can be remembered; a second one is lost.
                if (sample_edge) begin
                    if (edge_pending_q) begin
                        underrun_d = 1'b1;
                    end else begin
                        edge_pending_d = 1'b1;
                    end
                end
                if (state_q == S_FETCH) begin
                    if (!flash_waitrequest) begin
                        state_d = S_WAIT_DATA;
                    end
                end else if (flash_readdatavalid) begin
                    if (restart_pending_q || restart) begin
                        // Word belongs to the old position: drop it.
                        addr_d            = start_addr;
                        edge_pending_d    = 1'b0;
                        restart_pending_d = 1'b0;
                        state_d           = run_state;
                    end else begin
                        word_d  = flash_readdata;
                        state_d = S_WAIT_EDGE1;
                    end
                end
            end

            S_WAIT_EDGE1: begin
                if (restart) begin
                    addr_d         = start_addr;
                    edge_pending_d = 1'b0;
                    state_d        = run_state;
                end else if (play && (sample_edge || edge_pending_q)) begin
                    data_d         = direction ? word_q[31:16] : word_q[15:0];
                    valid_d        = 1'b1;
                    edge_pending_d = sample_edge & edge_pending_q;
                    state_d        = S_WAIT_EDGE2;
                end
            end

            S_WAIT_EDGE2: begin
                if (restart) begin
                    addr_d         = start_addr;
                    edge_pending_d = 1'b0;
                    state_d        = run_state;
                end else if (play && (sample_edge || edge_pending_q)) begin
                    data_d         = direction ? word_q[15:0] : word_q[31:16];
                    valid_d        = 1'b1;
                    edge_pending_d = sample_edge & edge_pending_q;
                    addr_d         = step_addr;
                    state_d        = run_state;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        read_d = (state_d == S_FETCH);
    end

    // State, datapath and synchronizer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q           <= S_IDLE;
            addr_q            <= 23'd0;
            read_q            <= 1'b0;
            data_q            <= 16'd0;
            valid_q           <= 1'b0;
            underrun_q        <= 1'b0;
            word_q            <= 32'd0;
            edge_pending_q    <= 1'b0;
            restart_pending_q <= 1'b0;
            sync1_q           <= 1'b0;
            sync2_q           <= 1'b0;
            prev_q            <= 1'b0;
        end else begin
            state_q           <= state_d;
            addr_q            <= addr_d;
            read_q            <= read_d;
            data_q            <= data_d;
            valid_q           <= valid_d;
            underrun_q        <= underrun_d;
            word_q            <= word_d;
            edge_pending_q    <= edge_pending_d;
            restart_pending_q <= restart_pending_d;
            sync1_q           <= sample_clk;
            sync2_q           <= sync1_q;
            prev_q            <= sync2_q;
        end
    end

    assign flash_read       = read_q;
    assign flash_address    = addr_q;
    assign flash_byteenable = 4'b1111;
    assign audio_data       = data_q;
    assign audio_valid      = valid_q;
    assign underrun         = underrun_q;

endmodule

// File: tb/tb_audio_sample_reader.sv
// Directed bench for audio_sample_reader with a small flash model.
module tb_audio_sample_reader;

    localparam logic [22:0] AMAX = 23'd15;

    logic        clk = 1'b0;
    logic        reset, sample_clk, play, direction, restart;
    logic        flash_waitrequest;
    logic [31:0] flash_readdata;
    logic        flash_readdatavalid;
    logic        flash_read;
    logic [22:0] flash_address;
    logic [3:0]  flash_byteenable;
    logic [15:0] audio_data;
    logic        audio_valid;
    logic        underrun;

    audio_sample_reader #(.ADDR_MAX(AMAX)) dut (
        .clk                 (clk),
        .reset               (reset),
        .sample_clk          (sample_clk),
        .play                (play),
        .direction           (direction),
        .restart             (restart),
        .flash_waitrequest   (flash_waitrequest),
        .flash_readdata      (flash_readdata),
        .flash_readdatavalid (flash_readdatavalid),
        .flash_read          (flash_read),
        .flash_address       (flash_address),
        .flash_byteenable    (flash_byteenable),
        .audio_data          (audio_data),
        .audio_valid         (audio_valid),
        .underrun            (underrun)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [16];
    int          rd_lat = 1;
    int          rd_cnt = 0;
    logic [3:0]  rd_addr = 4'd0;
    int          vcount = 0;
    int          total = 0;
    int          bad = 0;

    // Flash model: accepted read returns data rd_lat cycles later.
    always @(posedge clk) begin
        logic       acc;
        logic [3:0] a;
        acc = flash_read && !flash_waitrequest;
        a   = flash_address[3:0];
        #1;
        flash_readdatavalid = 1'b0;
        if (acc) begin
            rd_cnt  = rd_lat;
            rd_addr = a;
        end
        if (rd_cnt > 0) begin
            rd_cnt = rd_cnt - 1;
            if (rd_cnt == 0) begin
                flash_readdatavalid = 1'b1;
                flash_readdata      = mem[rd_addr];
            end
        end
    end

    // Count audio_valid cycles.
    always @(negedge clk) begin
        if (audio_valid === 1'b1) vcount = vcount + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic do_edge(output int lat);
        lat = -1;
        @(negedge clk);
        sample_clk = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            #1;
            if (audio_valid === 1'b1 && lat < 0) lat = i;
        end
        @(negedge clk);
        sample_clk = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic edge_chk(input string name, input logic [15:0] exp);
        int v0, l;
        v0 = vcount;
        do_edge(l);
        repeat (16) @(negedge clk);
        chk(name, {16'd0, audio_data}, {16'd0, exp});
        chk({name, "_cnt"}, 32'(vcount - v0), 32'd1);
    endtask

    task automatic wait_read(input logic want, input string name);
        int n;
        n = 0;
        while (flash_read !== want && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(name, {31'd0, flash_read}, {31'd0, want});
    endtask

    task automatic pulse_restart();
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
    endtask

    typedef struct {
        logic [15:0] exp_data;
        logic [22:0] exp_addr;
    } vec_t;

    vec_t tbl [6];

    initial begin
        int l, v0, v1;
        tbl[0] = '{16'hAAAA, 23'd0};
        tbl[1] = '{16'hBBBB, 23'd1};
        tbl[2] = '{16'hCCCC, 23'd1};
        tbl[3] = '{16'hDDDD, 23'd2};
        tbl[4] = '{16'hE004, 23'd2};
        tbl[5] = '{16'hE005, 23'd3};

        for (int i = 0; i < 16; i++) begin
            mem[i] = {16'hE000 + 16'(2 * i + 1), 16'hE000 + 16'(2 * i)};
        end
        mem[0]  = 32'hBBBB_AAAA;
        mem[1]  = 32'hDDDD_CCCC;
        mem[15] = 32'h2222_1111;

        reset = 1'b1; sample_clk = 1'b0; play = 1'b0; direction = 1'b0; restart = 1'b0;
        flash_waitrequest = 1'b0; flash_readdata = 32'd0; flash_readdatavalid = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_read", {31'd0, flash_read}, 32'd0);
        chk("rst_addr", {9'd0, flash_address}, 32'd0);
        chk("rst_data", {16'd0, audio_data}, 32'd0);
        chk("rst_valid", {31'd0, audio_valid}, 32'd0);
        chk("rst_underrun", {31'd0, underrun}, 32'd0);
        chk("byteenable", {28'd0, flash_byteenable}, 32'hF);
        reset = 1'b0;

        // Forward play through words 0..2
        play = 1'b1;
        repeat (20) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            v0 = vcount;
            do_edge(l);
            repeat (27) @(negedge clk);
            chk($sformatf("fwd%0d_data", i), {16'd0, audio_data}, {16'd0, tbl[i].exp_data});
            chk($sformatf("fwd%0d_cnt", i), 32'(vcount - v0), 32'd1);
            chk($sformatf("fwd%0d_lat", i), 32'(l), 32'd3);
            chk($sformatf("fwd%0d_addr", i), {9'd0, flash_address}, {9'd0, tbl[i].exp_addr});
        end

        // Backward from the top of memory
        direction = 1'b1;
        pulse_restart();
        repeat (20) @(negedge clk);
        edge_chk("bwd_first", 16'h2222);
        edge_chk("bwd_second", 16'h1111);
        chk("bwd_addr", {9'd0, flash_address}, 32'd14);

        // Backward wrap 0 -> ADDR_MAX
        direction = 1'b0;
        pulse_restart();
        repeat (20) @(negedge clk);
        direction = 1'b1;
        edge_chk("bwrap_first", 16'hBBBB);
        edge_chk("bwrap_second", 16'hAAAA);
        chk("bwrap_addr", {9'd0, flash_address}, {9'd0, AMAX});

        // Forward wrap ADDR_MAX -> 0
        direction = 1'b0;
        edge_chk("fwrap_first", 16'h1111);
        edge_chk("fwrap_second", 16'h2222);
        chk("fwrap_addr", {9'd0, flash_address}, 32'd0);

        // Pause in the second half
        edge_chk("pause_first", 16'hAAAA);
        play = 1'b0;
        v0 = vcount;
        for (int i = 0; i < 5; i++) do_edge(l);
        chk("pause_cnt", 32'(vcount - v0), 32'd0);
        chk("pause_data", {16'd0, audio_data}, 32'h0000AAAA);
        play = 1'b1;
        edge_chk("resume", 16'hBBBB);

        // Restart while waiting on data at address 5
        for (int i = 0; i < 7; i++) do_edge(l);
        repeat (10) @(negedge clk);
        chk("adv_data", {16'd0, audio_data}, 32'h0000E008);
        rd_lat = 10;
        @(negedge clk);
        sample_clk = 1'b1;
        wait_read(1'b1, "r5_read");
        chk("r5_addr", {9'd0, flash_address}, 32'd5);
        wait_read(1'b0, "r5_accept");
        pulse_restart();
        sample_clk = 1'b0;
        rd_lat = 1;
        v1 = vcount;
        chk("r5_last", {16'd0, audio_data}, 32'h0000E009);
        wait_read(1'b1, "rs_read");
        chk("rs_addr", {9'd0, flash_address}, 32'd0);
        repeat (20) @(negedge clk);
        chk("rs_noval", 32'(vcount - v1), 32'd0);
        edge_chk("rs_first", 16'hAAAA);

        // Stalled fetch: one pending edge, then an underrun
        flash_waitrequest = 1'b1;
        do_edge(l);
        chk("stall_data", {16'd0, audio_data}, 32'h0000BBBB);
        chk("ur_none", {31'd0, underrun}, 32'd0);
        do_edge(l);
        chk("ur_pending", {31'd0, underrun}, 32'd0);
        do_edge(l);
        chk("ur_set", {31'd0, underrun}, 32'd1);
        v0 = vcount;
        flash_waitrequest = 1'b0;
        repeat (20) @(negedge clk);
        chk("pend_data", {16'd0, audio_data}, 32'h0000CCCC);
        chk("pend_cnt", 32'(vcount - v0), 32'd1);
        chk("ur_sticky", {31'd0, underrun}, 32'd1);
        play = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("ur_clear", {31'd0, underrun}, 32'd0);
        chk("rst2_data", {16'd0, audio_data}, 32'd0);
        chk("rst2_addr", {9'd0, flash_address}, 32'd0);

        // Reset during an outstanding read; late data must be ignored
        rd_lat = 10;
        play = 1'b1;
        wait_read(1'b1, "late_read");
        wait_read(1'b0, "late_accept");
        play = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        rd_lat = 1;
        v0 = vcount;
        repeat (15) @(negedge clk);
        chk("late_noval", 32'(vcount - v0), 32'd0);
        chk("late_data", {16'd0, audio_data}, 32'd0);
        chk("late_idle", {31'd0, flash_read}, 32'd0);
        chk("late_addr", {9'd0, flash_address}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
